// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operands and opcode in, registered result and flags out.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, a, b, op, out_valid, out_ready, result, zero, negative, carry,
//        overflow, dbz, busy. The master modport is the requester; the slave modport is the ALU.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             dbz;
   logic             busy;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow, dbz, busy
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow, dbz, busy
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/MULHU/DIVU/REMU.
// Backpressure: one registered result slot; no accept while busy or while a result is unread.
// Ports: clk, rst (synchronous, active-high), bus (alu_mc_if.slave: request, result, flags, busy).
module alu_mc #(
   parameter int WIDTH = 32
) (
   input logic    clk,
   input logic    rst,
   alu_mc_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SLL   = 4'b0101;
   localparam logic [3:0] OP_SRL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_NOR   = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;
   localparam logic [3:0] OP_SLTU  = 4'b1110;

   logic [1:0]         state;
   logic [SHW-1:0]     cnt;
   logic [3:0]         op_q;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   dq;      // dividend bits shift out of the top, quotient bits shift in at the bottom
   logic [WIDTH-1:0]   dsr;
   logic [WIDTH-1:0]   a_q;
   logic               dbz_q;

   logic               out_valid_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q, negative_q, carry_q, overflow_q, dbz_out_q;

   logic accept, is_mul, is_div, last;
   assign accept = bus.in_valid && bus.in_ready;
   assign is_mul = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
   assign is_div = (bus.op == OP_DIVU) || (bus.op == OP_REMU);
   assign last   = (cnt == LAST);

   // ---------------- single-cycle datapath ----------------
   logic [WIDTH:0]   sum, diff;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;

   always_comb begin
      sum     = {1'b0, bus.a} + {1'b0, bus.b};
      diff    = {1'b0, bus.a} - {1'b0, bus.b};   // diff[WIDTH] is the unsigned borrow
      sh      = bus.b[SHW-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         OP_SLL:  alu_res = bus.a << sh;
         OP_SRL:  alu_res = bus.a >> sh;
         OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> sh);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_NOR:  alu_res = ~(bus.a | bus.b);
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         default: alu_res = '0;   // reserved opcode and multi-cycle ops
      endcase
   end

   // ---------------- iterative step logic ----------------
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH:0]     shifted, trial;
   logic               fits;
   logic [WIDTH-1:0]   rem_nxt, q_nxt;
   logic [WIDTH-1:0]   mul_res, div_res;

   always_comb begin
      prod_nxt = prod + (mplier[0] ? mcand : '0);
      shifted  = {rem, dq[WIDTH-1]};
      trial    = shifted - {1'b0, dsr};
      fits     = (shifted >= {1'b0, dsr});
      rem_nxt  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      q_nxt    = {dq[WIDTH-2:0], fits};
      // Final-step values are taken from the next-state terms so the result lands on the
      // same edge that returns the FSM to IDLE.
      mul_res  = (op_q == OP_MULHU) ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
      if (op_q == OP_DIVU) div_res = dbz_q ? '1 : q_nxt;
      else                 div_res = dbz_q ? a_q : rem_nxt;
   end

   // ---------------- result load selection ----------------
   logic             load_en;
   logic [WIDTH-1:0] load_res;
   logic             load_c, load_v, load_d;

   always_comb begin
      load_en  = 1'b0;
      load_res = alu_res;
      load_c   = alu_c;
      load_v   = alu_v;
      load_d   = 1'b0;
      if (state == IDLE && accept && !is_mul && !is_div) begin
         load_en = 1'b1;
      end else if (state == MUL && last) begin
         load_en  = 1'b1;
         load_res = mul_res;
         load_c   = 1'b0;
         load_v   = 1'b0;
      end else if (state == DIV && last) begin
         load_en  = 1'b1;
         load_res = div_res;
         load_c   = 1'b0;
         load_v   = 1'b0;
         load_d   = dbz_q;
      end
   end

   // ---------------- FSM and iteration registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         mcand  <= '0;
         prod   <= '0;
         mplier <= '0;
         rem    <= '0;
         dq     <= '0;
         dsr    <= '0;
         a_q    <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q <= bus.op;
                  cnt  <= '0;
                  if (is_mul) begin
                     state  <= MUL;
                     mcand  <= {{WIDTH{1'b0}}, bus.a};
                     mplier <= bus.b;
                     prod   <= '0;
                  end else if (is_div) begin
                     state <= DIV;
                     rem   <= '0;
                     dq    <= bus.a;
                     dsr   <= bus.b;
                     a_q   <= bus.a;
                     dbz_q <= (bus.b == '0);
                  end
               end
            end
            MUL: begin
               prod   <= prod_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (last) state <= IDLE;
            end
            DIV: begin
               rem <= rem_nxt;
               dq  <= q_nxt;
               cnt <= cnt + 1'b1;
               if (last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------- output slot ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         negative_q  <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         dbz_out_q   <= 1'b0;
      end else if (load_en) begin
         out_valid_q <= 1'b1;
         result_q    <= load_res;
         zero_q      <= (load_res == '0);
         negative_q  <= load_res[WIDTH-1];
         carry_q     <= load_c;
         overflow_q  <= load_v;
         dbz_out_q   <= load_d;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.negative  = negative_q;
   assign bus.carry     = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.dbz       = dbz_out_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed vectors feed an expected-result queue that a
// negedge monitor drains whenever a result is consumed; directed checks cover reset,
// multi-cycle latency, backpressure hold and reset abort.
module tb_alu_mc;
   logic clk;
   logic rst;
   int   total  = 0;
   int   passed = 0;
   int   stalls = 0;

   alu_mc_if #(.WIDTH(32)) bus ();
   alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [36:0] exp_q[$];    // {result, zero, negative, carry, overflow, dbz}
   string       name_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h, expected %h", name, got, want);
   endtask

   // Scoreboard monitor: one pop per consumed result.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {27'd0, bus.result, 5'd0}, 64'hDEAD);
         end else begin
            logic [36:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, {27'd0, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow, bus.dbz},
                  {27'd0, e});
         end
      end
   end

   // Present a request, wait for acceptance (bounded), optionally record its expectation.
   task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] fl, input bit push);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.op = op;
      bus.a  = a;
      bus.b  = b;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            if (push) begin
               exp_q.push_back({res, fl});
               name_q.push_back(nm);
            end
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check({nm, "_accept_timeout"}, 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      bus.a = $urandom;   // later changes must not affect the captured request
      bus.b = $urandom;
      bus.op = 4'($urandom_range(0, 15));
   endtask

   task automatic send(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [4:0] fl);
      issue(nm, op, a, b, res, fl, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
   endtask

   initial begin
      int first, busy_cnt, rdy_bad, ov_cnt;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0;
      bus.b = '0;
      bus.op = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("reset_state", {26'd0, bus.out_valid, bus.result, bus.zero, bus.negative, bus.carry,
                            bus.overflow, bus.dbz, bus.busy, bus.in_ready},
            {26'd0, 1'b0, 32'h0, 5'b00000, 1'b0, 1'b1});
      @(posedge clk);
      #1;

      // Single-cycle ops back to back; flags are {zero,negative,carry,overflow,dbz}.
      stalls = 0;
      send("add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
      send("sub_ovf",    4'b0001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00010);
      send("sub_borrow", 4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'b01100);
      send("add_ovf",    4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
      send("and",        4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000);
      send("or",         4'b0011, 32'h12340000, 32'h00005678, 32'h12345678, 5'b00000);
      send("xor",        4'b0100, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 5'b00000);
      send("sll_mask",   4'b0101, 32'h00000001, 32'h0000003F, 32'h80000000, 5'b01000);
      send("srl",        4'b0110, 32'h80000000, 32'h00000004, 32'h08000000, 5'b00000);
      send("sra",        4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000);
      send("slt",        4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
      send("sltu",       4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000);
      send("nor",        4'b1001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'b01000);
      send("reserved",   4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10000);
      check("back_to_back_stalls", 64'(stalls), 64'd0);

      // Multi-cycle ops.
      send("mul",        4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00000);
      send("mulhu",      4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b01000);
      send("mul_mid",    4'b1010, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 5'b01000);
      send("mulhu_zero", 4'b1011, 32'h0000FFFF, 32'h00010001, 32'h00000000, 5'b10000);
      send("divu",       4'b1100, 32'h00000064, 32'h00000007, 32'h0000000E, 5'b00000);
      send("remu",       4'b1101, 32'h00000064, 32'h00000007, 32'h00000002, 5'b00000);
      send("divu_dbz",   4'b1100, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 5'b01001);
      send("remu_dbz",   4'b1101, 32'h00000064, 32'h00000000, 32'h00000064, 5'b00001);
      drain();

      // MUL latency: accept in cycle 0, result visible in cycle 33, busy for 32 cycles.
      send("mul_lat", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'b00000);
      first = 0; busy_cnt = 0; rdy_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.busy && bus.in_ready) rdy_bad++;
         if (bus.out_valid && first == 0) first = k;
      end
      check("mul_latency", 64'(first), 64'd33);
      check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
      check("mul_in_ready_low", 64'(rdy_bad), 64'd0);
      @(posedge clk);
      #1;

      // Backpressure: SRA result held for 5 cycles while a second request waits.
      bus.out_ready = 1'b0;
      send("sra_hold", 4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000);
      bus.in_valid = 1'b1;
      bus.op = 4'b0000;
      bus.a = 32'd2;
      bus.b = 32'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_stable", {30'd0, bus.out_valid, bus.result, bus.in_ready},
               {30'd0, 1'b1, 32'hF8000000, 1'b0});
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send("add_after_hold", 4'b0000, 32'd2, 32'd3, 32'd5, 5'b00000);
      @(negedge clk);
      check("second_next_cycle", {31'd0, bus.out_valid, bus.result}, {31'd0, 1'b1, 32'd5});
      @(posedge clk);
      #1;
      drain();

      // Reset during DIVU aborts it.
      issue("divu_abort", 4'b1100, 32'h00000064, 32'h00000007, 32'h0, 5'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_outputs", {26'd0, bus.out_valid, bus.result, bus.zero, bus.negative, bus.carry,
                              bus.overflow, bus.dbz, bus.busy, bus.in_ready},
            {26'd0, 1'b0, 32'h0, 5'b00000, 1'b0, 1'b1});
      ov_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) ov_cnt++;
      end
      check("abort_no_result", 64'(ov_cnt), 64'd0);
      @(posedge clk);
      #1;
      send("add_after_abort", 4'b0000, 32'd2, 32'd3, 32'd5, 5'b00000);
      drain();

      // Reset wins over a simultaneous accept.
      bus.in_valid = 1'b1;
      bus.op = 4'b0000;
      bus.a = 32'd1;
      bus.b = 32'd1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_priority", {62'd0, bus.out_valid, bus.busy}, 64'd0);
      @(posedge clk);
      #1;

      drain();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Derived localparam SHW = log2(WIDTH), shift-amount width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present on a, b, op.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 op  input  4  operation code.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero, negative, carry, overflow, dbz  output  1 each  registered flags.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 NOR, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU, 1110 SLTU; 1111 reserved.
REQ-016 Shifts use b[SHW-1:0]; SRA fills with a[WIDTH-1]; SLT/SLTU yield 1 or 0 zero-extended.
REQ-017 Accept = in_valid && in_ready; a, b, op captured at accept; later input changes ignored.
REQ-018 in_ready = (state == IDLE) && (!out_valid || out_ready); combinational from state and out_ready only, never from in_valid.
REQ-019 States: IDLE, MUL, DIV; busy = (state != IDLE).
REQ-020 Single-cycle ops (all except 1010-1101): result/flags loaded and out_valid set on the edge of acceptance (visible next cycle); back-to-back accepts sustain one result per cycle when out_ready held high.
REQ-021 MUL/MULHU: IDLE -> MUL at accept; radix-2 shift-add over WIDTH cycles on a 2*WIDTH product; MUL -> IDLE with out_valid set after exactly WIDTH cycles in MUL (out_valid first high WIDTH+1 cycles after accept cycle).
REQ-022 DIVU/REMU: IDLE -> DIV at accept; restoring division, one quotient bit per cycle, same WIDTH-cycle latency as REQ-021.
REQ-023 Divide by zero: quotient all ones, remainder = a, dbz = 1; latency unchanged.
REQ-024 Reserved opcode 1111: result 0, zero = 1, other flags 0, single-cycle.
REQ-025 zero = (result == 0); negative = result[WIDTH-1], for every op.
REQ-026 carry: ADD carry-out; SUB 1 when a < b unsigned (borrow); 0 for all other ops.
REQ-027 overflow: signed overflow for ADD and SUB only; 0 otherwise. dbz 0 except REQ-023.
REQ-028 out_valid, once set, holds with result/flags stable until a cycle with out_ready = 1; then clears unless a new result loads on that same edge.
REQ-029 No request is accepted while out_valid && !out_ready, nor while busy.
REQ-030 Results return strictly in acceptance order; no result is ever dropped or duplicated.

Reset
REQ-031 rst = 1 on an edge: state = IDLE, out_valid = 0, result = 0, all flags 0, busy = 0; in_ready = 1 in the first cycle after rst deasserts.
REQ-032 rst during MUL/DIV aborts the operation; no out_valid produced for it.
REQ-033 rst has priority over any accept in the same cycle; that request is discarded.

Verification
REQ-034 WIDTH=32, ADD a=FFFFFFFF b=1 -> next cycle result 0, zero=1, carry=1, overflow=0.
REQ-035 WIDTH=32, SUB a=80000000 b=1 -> result 7FFFFFFF, overflow=1, carry=0, negative=0.
REQ-036 WIDTH=32, MUL a=FFFFFFFF b=FFFFFFFF -> out_valid exactly 33 cycles after accept, result 00000001; MULHU same operands -> FFFFFFFE; busy high 32 cycles, in_ready low throughout.
REQ-037 WIDTH=16, DIVU a=0064 b=0007 -> 000E; REMU -> 0002; DIVU b=0 -> FFFF, dbz=1; REMU b=0 -> 0064, dbz=1.
REQ-038 out_ready held 0 for 5 cycles after SRA a=80000000 b=4 -> result F8000000 stable, in_ready 0, second request waits; out_ready=1 -> second result next cycle, order preserved.
REQ-039 rst pulsed at cycle 10 of DIVU -> no out_valid, all outputs 0, in_ready 1 the cycle after rst drops; subsequent ADD 2+3 -> 5.
